// File: rtl/opb_cram_arbiter.sv
// rtl/opb_cram_arbiter.sv - round-robin two-port arbiter onto a single OPB CRAM controller port
`timescale 1ns/1ps
module opb_cram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic        a_req,
    input  logic        a_rnw,
    input  logic        a_32bit,
    input  logic [23:0] a_addr,
    input  logic [3:0]  a_be,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_rnw,
    input  logic        b_32bit,
    input  logic [23:0] b_addr,
    input  logic [3:0]  b_be,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic [23:0] OPB_ABus,
    output logic [3:0]  OPB_BE,
    output logic [31:0] OPB_DBus,
    output logic        OPB_32Bit,
    output logic        OPB_RNW,
    output logic        OPB_select,
    input  logic [31:0] Sln_DBus,
    input  logic        Sln_xferAck
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_b;
    logic          cur_b;
    logic          grant_b;
    logic          start;
    logic          finish;
    logic          expired;
    logic [CW-1:0] wdog;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        expired   = 1'b0;
        grant_b   = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    start     = 1'b1;
                    // on a tie the port that did not win last time goes next
                    grant_b   = b_req && (!a_req || !last_b);
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (Sln_xferAck) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else if (TIMEOUT != 0 && wdog == TMO) begin
                    finish    = 1'b1;
                    expired   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            last_b     <= 1'b1;
            cur_b      <= 1'b0;
            wdog       <= '0;
            a_ack      <= 1'b0;
            a_err      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_err      <= 1'b0;
            b_rdata    <= '0;
            OPB_ABus   <= '0;
            OPB_BE     <= '0;
            OPB_DBus   <= '0;
            OPB_32Bit  <= 1'b0;
            OPB_RNW    <= 1'b0;
            OPB_select <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            if (start) begin
                cur_b      <= grant_b;
                OPB_ABus   <= grant_b ? b_addr  : a_addr;
                OPB_BE     <= grant_b ? b_be    : a_be;
                OPB_DBus   <= grant_b ? b_wdata : a_wdata;
                OPB_32Bit  <= grant_b ? b_32bit : a_32bit;
                OPB_RNW    <= grant_b ? b_rnw   : a_rnw;
                OPB_select <= 1'b1;
                wdog       <= '0;
            end
            if (state == XFER && TIMEOUT != 0) wdog <= wdog + CW'(1);
            if (finish) begin
                OPB_select <= 1'b0;
                last_b     <= cur_b;
                a_ack      <= !cur_b;
                b_ack      <= cur_b;
                a_err      <= expired && !cur_b;
                b_err      <= expired && cur_b;
                if (expired) begin
                    if (cur_b) b_rdata <= '0;
                    else       a_rdata <= '0;
                end else if (OPB_RNW) begin
                    if (cur_b) b_rdata <= Sln_DBus;
                    else       a_rdata <= Sln_DBus;
                end
            end
        end
    end
endmodule

// File: tb/tb_opb_cram_arbiter.sv
// tb/tb_opb_cram_arbiter.sv - randomized self-checking bench for opb_cram_arbiter
`timescale 1ns/1ps
module tb_opb_cram_arbiter;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, b_req = 0, a_rnw = 0, b_rnw = 0, a_32 = 0, b_32 = 0;
    logic [23:0] a_addr = 0, b_addr = 0;
    logic [3:0]  a_be = 0, b_be = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0, sln_dbus = 0;
    logic        sln_ack = 0;
    logic        no_ack = 0;

    logic        a_ack, b_ack, a_err, b_err, opb_32, opb_rnw, opb_sel;
    logic [31:0] a_rdata, b_rdata, opb_dbus;
    logic [23:0] opb_abus;
    logic [3:0]  opb_be;

    logic        z_a_ack, z_b_ack, z_a_err, z_b_err, z_32, z_rnw, z_sel;
    logic [31:0] z_a_rdata, z_b_rdata, z_dbus;
    logic [23:0] z_abus;
    logic [3:0]  z_be;

    opb_cram_arbiter #(.TIMEOUT(TMO)) dut (
        .OPB_Clk(clk), .OPB_Rst(rst),
        .a_req(a_req), .a_rnw(a_rnw), .a_32bit(a_32), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_rnw(b_rnw), .b_32bit(b_32), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .OPB_ABus(opb_abus), .OPB_BE(opb_be), .OPB_DBus(opb_dbus), .OPB_32Bit(opb_32),
        .OPB_RNW(opb_rnw), .OPB_select(opb_sel), .Sln_DBus(sln_dbus), .Sln_xferAck(sln_ack)
    );

    // watchdog disabled and a controller that never answers: must hang in the transfer forever
    opb_cram_arbiter #(.TIMEOUT(0)) dut_nowd (
        .OPB_Clk(clk), .OPB_Rst(rst),
        .a_req(a_req), .a_rnw(a_rnw), .a_32bit(a_32), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ack(z_a_ack), .a_err(z_a_err), .a_rdata(z_a_rdata),
        .b_req(b_req), .b_rnw(b_rnw), .b_32bit(b_32), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ack(z_b_ack), .b_err(z_b_err), .b_rdata(z_b_rdata),
        .OPB_ABus(z_abus), .OPB_BE(z_be), .OPB_DBus(z_dbus), .OPB_32Bit(z_32),
        .OPB_RNW(z_rnw), .OPB_select(z_sel), .Sln_DBus(sln_dbus), .Sln_xferAck(no_ack)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: transaction schedule in cycle numbers ----------------
    int          mcyc = 0;
    bit          m_busy = 0, m_port = 0, m_last = 1, m_ack = 0, m_err = 0;
    int          m_start = 0, m_ack_cyc = -1000;
    logic [23:0] m_abus = 0;
    logic [3:0]  m_be = 0;
    logic [31:0] m_dbus = 0;
    logic        m_32 = 0, m_rnw = 0;
    logic [31:0] m_rd [2] = '{0, 0};
    bit          z_busy = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_port = 0; m_last = 1; m_ack = 0; m_err = 0; m_ack_cyc = -1000;
            m_abus = 0; m_be = 0; m_dbus = 0; m_32 = 0; m_rnw = 0;
            m_rd[0] = 0; m_rd[1] = 0;
            z_busy = 0;
        end else begin
            mcyc++;
            m_ack = 0;
            if (a_req || b_req) z_busy = 1;
            if (m_busy) begin
                if (sln_ack) begin
                    m_ack = 1; m_err = 0;
                    if (m_rnw) m_rd[m_port] = sln_dbus;
                end else if (mcyc - m_start == TMO + 1) begin
                    m_ack = 1; m_err = 1;
                    m_rd[m_port] = 0;
                end
                if (m_ack) begin
                    m_busy = 0; m_last = m_port; m_ack_cyc = mcyc;
                end
            end else if (mcyc >= m_ack_cyc + 2 && (a_req || b_req)) begin
                m_port  = (a_req && b_req) ? !m_last : b_req;
                m_abus  = m_port ? b_addr  : a_addr;
                m_be    = m_port ? b_be    : a_be;
                m_dbus  = m_port ? b_wdata : a_wdata;
                m_32    = m_port ? b_32    : a_32;
                m_rnw   = m_port ? b_rnw   : a_rnw;
                m_busy  = 1;
                m_start = mcyc;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit seen_a = 0, seen_b = 0, prev_sel = 0, had_txn = 0;
    int low_run = 0;

    always @(negedge clk) begin
        chk("select",  opb_sel,  m_busy);
        chk("a_ack",   a_ack,    m_ack && !m_port);
        chk("b_ack",   b_ack,    m_ack && m_port);
        chk("a_err",   a_err,    m_ack && !m_port && m_err);
        chk("b_err",   b_err,    m_ack && m_port && m_err);
        chk("a_rdata", a_rdata,  m_rd[0]);
        chk("b_rdata", b_rdata,  m_rd[1]);
        chk("abus",    opb_abus, m_abus);
        chk("be",      opb_be,   m_be);
        chk("dbus",    opb_dbus, m_dbus);
        chk("32bit",   opb_32,   m_32);
        chk("rnw",     opb_rnw,  m_rnw);
        chk("nowd_select", z_sel, z_busy);
        chk("nowd_ack", z_a_ack | z_b_ack, 0);
        if (rst) begin
            had_txn = 0; low_run = 0;
        end else if (opb_sel) begin
            if (!prev_sel && had_txn) chk("select_gap_ge2", low_run >= 2, 1);
            had_txn = 1; low_run = 0;
        end else begin
            low_run++;
        end
        prev_sel = opb_sel;
        seen_a = a_ack;
        seen_b = b_ack;
    end

    // ---------------- controller model and requesters ----------------
    int   force_lat = 3, ctl_lat = 0, ctl_k = 0;
    bit   ctl_prev = 0, spurious = 0, auto_req = 0, force_data_en = 0;
    logic [31:0] force_data = 0;

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return $urandom_range(0, 4);
        if (r == 7) return TMO;
        if (r == 8) return TMO - 1;
        return 1000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (opb_sel && !ctl_prev) begin
            ctl_k = 0;
            ctl_lat = (force_lat >= 0) ? force_lat : pick_lat();
        end else begin
            ctl_k++;
        end
        ctl_prev = opb_sel;
        sln_ack  = opb_sel ? (ctl_k == ctl_lat) : (spurious && $urandom_range(0, 7) == 0);
        sln_dbus = force_data_en ? force_data : $urandom;
        if (auto_req) begin
            if (seen_a) a_req = 0;
            else if (!a_req && $urandom_range(0, 3) == 0) begin
                a_rnw = 1'($urandom); a_32 = 1'($urandom); a_addr = 24'($urandom);
                a_be = 4'($urandom); a_wdata = $urandom; a_req = 1;
            end
            if (seen_b) b_req = 0;
            else if (!b_req && $urandom_range(0, 3) == 0) begin
                b_rnw = 1'($urandom); b_32 = 1'($urandom); b_addr = 24'($urandom);
                b_be = 4'($urandom); b_wdata = $urandom; b_req = 1;
            end
        end
    endtask

    task automatic wait_port_ack(input bit port, input int limit, output int n);
        n = 0;
        do begin step(); n++; end while (!(port ? b_ack : a_ack) && n < limit);
        if (!(port ? b_ack : a_ack)) begin
            vectors++; miscompares++;
            $display("FAIL wait_ack port %0d: no ack within %0d cycles", port, limit);
        end
    endtask

    task automatic wait_any_ack(input int limit, output int port);
        int n = 0;
        do begin step(); n++; end while (!(a_ack || b_ack) && n < limit);
        port = b_ack ? 1 : (a_ack ? 0 : -1);
        if (port < 0) begin
            vectors++; miscompares++;
            $display("FAIL wait_any_ack: no ack within %0d cycles", limit);
        end
    endtask

    initial begin
        int n, p;
        int order [4];
        repeat (3) step();
        chk("rst_select", opb_sel, 0);
        chk("rst_abus", opb_abus, 0);
        chk("rst_rdata", a_rdata | b_rdata, 0);
        rst = 0;

        // A write alone, controller acks 3 cycles after select
        a_addr = 24'h000100; a_wdata = 32'hCAFEBABE; a_be = 4'hF; a_32 = 1; a_rnw = 0; a_req = 1;
        force_lat = 3;
        step();
        chk("t1_select", opb_sel, 1);
        chk("t1_abus", opb_abus, 24'h000100);
        chk("t1_dbus", opb_dbus, 32'hCAFEBABE);
        chk("t1_be", opb_be, 4'hF);
        chk("t1_32bit", opb_32, 1);
        chk("t1_rnw", opb_rnw, 0);
        wait_port_ack(0, 20, n);
        chk("t1_ack_latency", n, 4);
        chk("t1_err", a_err, 0);
        chk("t1_b_ack", b_ack, 0);
        step(); a_req = 0;
        chk("t1_ack_one_cycle", a_ack, 0);

        // B read alone, 16-bit, then an A write must not disturb b_rdata
        b_addr = 24'h3FFFFE; b_32 = 0; b_rnw = 1; b_be = 4'h3; b_req = 1;
        force_lat = 1; force_data_en = 1; force_data = 32'h00001234;
        wait_port_ack(1, 20, n);
        chk("t2_rdata", b_rdata, 32'h00001234);
        step(); b_req = 0;
        force_data_en = 0;
        a_req = 1;
        wait_port_ack(0, 20, n);
        step(); a_req = 0;
        chk("t2_rdata_hold", b_rdata, 32'h00001234);

        // simultaneous requests out of reset, both held
        rst = 1;
        a_addr = 24'h111111; a_rnw = 1; b_addr = 24'h222222; b_rnw = 1;
        a_req = 1; b_req = 1; force_lat = 2;
        repeat (2) step();
        rst = 0;
        for (int i = 0; i < 4; i++) wait_any_ack(40, order[i]);
        step(); a_req = 0; b_req = 0;
        chk("t3_order0", order[0], 0);
        chk("t3_order1", order[1], 1);
        chk("t3_order2", order[2], 0);
        chk("t3_order3", order[3], 1);

        // watchdog expiry: controller never acks
        step();
        force_lat = 1000; a_req = 1; a_rnw = 1;
        step();
        wait_port_ack(0, 30, n);
        chk("t4_wd_latency", n, 9);
        chk("t4_err", a_err, 1);
        chk("t4_rdata_zero", a_rdata, 0);
        step(); a_req = 0;

        // ack lands on the expiry cycle: ack wins
        force_lat = TMO; force_data_en = 1; force_data = 32'hA5A50F0F; a_req = 1;
        step();
        wait_port_ack(0, 30, n);
        chk("t5_latency", n, 9);
        chk("t5_err", a_err, 0);
        chk("t5_rdata", a_rdata, 32'hA5A50F0F);
        step(); a_req = 0; force_data_en = 0;

        // reset two cycles into a B read
        force_lat = 1000; b_rnw = 1; b_req = 1;
        repeat (3) step();
        chk("t6_select_before", opb_sel, 1);
        rst = 1;
        #1;
        chk("t6_select_async", opb_sel, 0);
        chk("t6_abus_async", opb_abus, 0);
        chk("t6_rdata_async", a_rdata | b_rdata, 0);
        force_lat = 2;
        repeat (2) step();
        rst = 0;
        wait_port_ack(1, 20, n);
        chk("t6_reserve_latency", n, 4);
        step(); b_req = 0;

        // randomized traffic
        force_lat = -1; spurious = 1; auto_req = 1;
        repeat (3000) step();
        auto_req = 0; a_req = 0; b_req = 0;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
